// File: rtl/core_pkg.sv
// Shared types for the memory-port arbiter: FSM states and owner encodings.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mux2.sv
// Generic two-input mux; sel_i=0 picks a_i, sel_i=1 picks b_i.
module mux2 #(
  parameter int W = 32
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  // Pure combinational select.
  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (I) and load/store (D).
// One transaction outstanding; D has priority unless I has waited through
// STREAK_MAX consecutive D grants. Responses go back to the issuing owner.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              owner
);

  localparam int BW = XLEN / 8;
  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STREAK_MAX);

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;

  logic            sel;
  logic            gnt;
  logic            rsp;
  logic [XLEN-1:0] addr_mux, wdata_mux;
  logic [BW-1:0]   be_mux;

  // Steering muxes: I side supplies fixed write-data/byte-enable values.
  mux2 #(.W(XLEN)) u_addr_mux (
    .sel_i(sel), .a_i(i_addr), .b_i(d_addr), .y_o(addr_mux)
  );
  mux2 #(.W(XLEN)) u_wdata_mux (
    .sel_i(sel), .a_i('0), .b_i(d_wdata), .y_o(wdata_mux)
  );
  mux2 #(.W(BW)) u_be_mux (
    .sel_i(sel), .a_i({BW{1'b1}}), .b_i(d_be), .y_o(be_mux)
  );

  // Arbitration, output steering and next-state logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    sel      = owner_q;
    mem_req  = 1'b0;

    case (state_q)
      IDLE: begin
        // D wins unless I has been passed over STREAK_MAX times in a row.
        sel     = (d_req && !(i_req && streak_q == SMAX)) ? OWN_D : OWN_I;
        mem_req = i_req | d_req;
        if (mem_req) begin
          owner_d = sel;
          state_d = mem_gnt ? WAIT : REQ;
        end
      end
      REQ: begin
        // Owner is locked; a late-arriving requester cannot steal the port.
        mem_req = 1'b1;
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    gnt = mem_req & mem_gnt;
    if (gnt) begin
      if (sel == OWN_D) streak_d = i_req ? ((streak_q == SMAX) ? SMAX : streak_q + 1'b1) : '0;
      else              streak_d = '0;
    end
  end

  assign owner     = sel;
  assign i_gnt     = gnt & (sel == OWN_I);
  assign d_gnt     = gnt & (sel == OWN_D);
  assign mem_addr  = mem_req ? addr_mux  : '0;
  assign mem_wdata = mem_req ? wdata_mux : '0;
  assign mem_be    = mem_req ? be_mux    : '0;
  assign mem_we    = mem_req & (sel == OWN_D) & d_we;

  // Responses only count while a transaction is outstanding.
  assign rsp      = (state_q == WAIT) & mem_rvalid;
  assign i_rvalid = rsp & (owner_q == OWN_I);
  assign d_rvalid = rsp & (owner_q == OWN_D);
  assign i_rdata  = (state_q == WAIT && owner_q == OWN_I) ? mem_rdata : '0;
  assign d_rdata  = (state_q == WAIT && owner_q == OWN_D) ? mem_rdata : '0;

  // State, owner and streak registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule
